// File: rtl/mem_responder_pkg.sv
// ============================================================================
// Module  : mem_pkg
// Brief   : Shared FSM encoding, default widths and opcodes for mem_responder.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_pkg;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_BITS  = 9;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;
endpackage

`default_nettype wire

// File: rtl/mem_responder_if.sv
// ============================================================================
// Module  : mem_responder_if
// Brief   : Strobe/bus bundle between the control unit/datapath and mem_responder.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_responder_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  mem_enable;
    logic                  mem_read;
    logic                  mem_write;
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  mem_ready;
    logic                  mem_busy;
    logic                  addr_err;

    modport master (
        output mem_enable, mem_read, mem_write, addr, wdata,
        input  rdata, mem_ready, mem_busy, addr_err
    );

    modport slave (
        input  mem_enable, mem_read, mem_write, addr, wdata,
        output rdata, mem_ready, mem_busy, addr_err
    );
endinterface

`default_nettype wire

// File: rtl/mem_responder_array.sv
// ============================================================================
// Module  : mem_array_512x32
// Brief   : Synchronous single-port array, write-enable, registered read port.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_array_512x32 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 9
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_we,
    input  wire logic                  i_re,
    input  wire logic                  i_rd_zero,
    input  wire logic [ADDR_BITS-1:0]  i_addr,
    input  wire logic [DATA_WIDTH-1:0] i_wdata,
    output logic      [DATA_WIDTH-1:0] o_rdata
);
    localparam int c_DEPTH = 2 ** ADDR_BITS;

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Storage is deliberately not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= i_rd_zero ? '0 : r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// Module  : mem_responder
// Brief   : Wait-state memory responder; optional range check via
//           MEM_RESPONDER_ADDR_CHECK_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int ADDR_BITS   = DEFAULT_ADDR_BITS,
    parameter int WAIT_CYCLES = 1
) (
    input wire logic         clk,
    input wire logic         reset,
    mem_responder_if.slave   bus
);
    localparam logic [3:0] c_WAIT_INIT = 4'(WAIT_CYCLES);
    localparam bit         c_ZERO_WAIT = (WAIT_CYCLES == 0);

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [3:0]            r_cnt;
    logic                  r_op;
    logic                  r_oor;
    logic [ADDR_BITS-1:0]  r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic                  w_accept;
    logic                  w_req_oor;
    logic                  w_fire;
    logic                  w_op;
    logic                  w_oor;
    logic [ADDR_BITS-1:0]  w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_accept = !reset && (r_state == S_IDLE) && bus.mem_enable
                      && (bus.mem_read || bus.mem_write);

`ifdef MEM_RESPONDER_ADDR_CHECK_EN
    logic r_addr_err;
    assign w_req_oor = |bus.addr[DATA_WIDTH-1:ADDR_BITS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr_err <= 1'b0;
        end else if (w_accept && w_req_oor) begin
            r_addr_err <= 1'b1;
        end
    end
`else
    logic w_unused_upper;
    assign w_unused_upper = ^bus.addr[DATA_WIDTH-1:ADDR_BITS];
    assign w_req_oor      = 1'b0;
`endif

    // Zero wait states operate on the accept edge, so the live bus is used.
    assign w_fire  = c_ZERO_WAIT ? w_accept
                                 : ((r_state == S_WAIT) && (r_cnt == 4'd1));
    assign w_op    = c_ZERO_WAIT ? (bus.mem_write ? OP_WRITE : OP_READ) : r_op;
    assign w_addr  = c_ZERO_WAIT ? bus.addr[ADDR_BITS-1:0] : r_addr;
    assign w_wdata = c_ZERO_WAIT ? bus.wdata : r_wdata;
    assign w_oor   = c_ZERO_WAIT ? w_req_oor : r_oor;

    mem_array_512x32 #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (ADDR_BITS)
    ) u_array (
        .clk       (clk),
        .rst       (reset),
        .i_we      (w_fire && (w_op == OP_WRITE) && !w_oor),
        .i_re      (w_fire && (w_op == OP_READ)),
        .i_rd_zero (w_oor),
        .i_addr    (w_addr),
        .i_wdata   (w_wdata),
        .o_rdata   (w_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next_state = c_ZERO_WAIT ? S_DONE : S_WAIT;
            S_WAIT: if (r_cnt == 4'd1) w_next_state = S_DONE;
            S_DONE: w_next_state = bus.mem_enable ? S_HOLD : S_IDLE;
            S_HOLD: if (!bus.mem_enable) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= 4'd0;
            r_op    <= OP_READ;
            r_oor   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_cnt   <= c_WAIT_INIT;
            r_op    <= bus.mem_write ? OP_WRITE : OP_READ;
            r_oor   <= w_req_oor;
            r_addr  <= bus.addr[ADDR_BITS-1:0];
            r_wdata <= bus.wdata;
        end else if (r_state == S_WAIT) begin
            r_cnt   <= r_cnt - 4'd1;
        end
    end

    always_comb begin
        bus.mem_busy  = (r_state == S_WAIT);
        bus.mem_ready = (r_state == S_DONE);
        bus.rdata     = w_rdata;
`ifdef MEM_RESPONDER_ADDR_CHECK_EN
        bus.addr_err  = r_addr_err;
`else
        bus.addr_err  = 1'b0;
`endif
    end
endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// Module  : tb_mem_responder
// Brief   : Directed vectors for mem_responder at WAIT_CYCLES 0, 1 and 3.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_responder;
    logic        clk = 1'b0;
    logic [3:0]  rst = 4'hF;
    logic [3:0]  en  = 4'h0;
    logic        t_rd = 1'b0;
    logic        t_wr = 1'b0;
    logic [31:0] t_addr = '0;
    logic [31:0] t_wdata = '0;
    int          n_err = 0;
    int          n_chk = 0;

    always #5 clk = ~clk;

    mem_responder_if #(.DATA_WIDTH(32)) if0 ();
    mem_responder_if #(.DATA_WIDTH(32)) if1 ();
    mem_responder_if #(.DATA_WIDTH(32)) if3 ();

    assign if0.mem_enable = en[0];
    assign if1.mem_enable = en[1];
    assign if3.mem_enable = en[3];
    assign if0.mem_read = t_rd;  assign if1.mem_read = t_rd;  assign if3.mem_read = t_rd;
    assign if0.mem_write = t_wr; assign if1.mem_write = t_wr; assign if3.mem_write = t_wr;
    assign if0.addr = t_addr;    assign if1.addr = t_addr;    assign if3.addr = t_addr;
    assign if0.wdata = t_wdata;  assign if1.wdata = t_wdata;  assign if3.wdata = t_wdata;

    mem_responder #(.DATA_WIDTH(32), .ADDR_BITS(9), .WAIT_CYCLES(0)) dut0 (.clk(clk), .reset(rst[0]), .bus(if0));
    mem_responder #(.DATA_WIDTH(32), .ADDR_BITS(9), .WAIT_CYCLES(1)) dut1 (.clk(clk), .reset(rst[1]), .bus(if1));
    mem_responder #(.DATA_WIDTH(32), .ADDR_BITS(9), .WAIT_CYCLES(3)) dut3 (.clk(clk), .reset(rst[3]), .bus(if3));

    function automatic logic g_rdy(input int s);
        case (s) 0: return if0.mem_ready; 1: return if1.mem_ready; default: return if3.mem_ready; endcase
    endfunction
    function automatic logic g_busy(input int s);
        case (s) 0: return if0.mem_busy; 1: return if1.mem_busy; default: return if3.mem_busy; endcase
    endfunction
    function automatic logic g_err(input int s);
        case (s) 0: return if0.addr_err; 1: return if1.addr_err; default: return if3.addr_err; endcase
    endfunction
    function automatic logic [31:0] g_rdata(input int s);
        case (s) 0: return if0.rdata; 1: return if1.rdata; default: return if3.rdata; endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // One request; strobes held for 'hold' cycles, addr/wdata scrambled after accept.
    task automatic txn(input int s, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input int hold, output int lat, output int nrdy,
                       output logic [31:0] rdat, output logic busy);
        lat = -1; nrdy = 0; rdat = '0; busy = 1'b0;
        @(negedge clk);
        t_rd = rd; t_wr = wr; t_addr = a; t_wdata = d; en[s] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (g_rdy(s)) begin
                nrdy++;
                if (lat < 0) begin lat = k; rdat = g_rdata(s); end
            end
            if (g_busy(s)) busy = 1'b1;
            if (k == 1) begin t_addr = t_addr ^ 32'h33; t_wdata = ~t_wdata; end
            if (k >= hold) begin en[s] = 1'b0; t_rd = 1'b0; t_wr = 1'b0; end
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t        vecs[11];
    int          lat, nrdy;
    logic [31:0] rdat;
    logic        busy;
    logic        e8;

    initial begin
`ifdef MEM_RESPONDER_ADDR_CHECK_EN
        e8 = 1'b1;
        vecs[9]  = '{1'b1, 1'b0, 32'h000, 32'h0,        1, 32'h13572468, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 32'h200, 32'h0,        1, 32'h00000000, 1'b1};
`else
        e8 = 1'b0;
        vecs[9]  = '{1'b1, 1'b0, 32'h000, 32'h0,        1, 32'h77777777, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 32'h200, 32'h0,        1, 32'h77777777, 1'b0};
`endif
        vecs[0]  = '{1'b0, 1'b1, 32'h000, 32'h13572468, 1, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 32'h005, 32'hDEADBEEF, 1, 32'h00000000, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h005, 32'h0,        1, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 32'h010, 32'hA5A5A5A5, 1, 32'hDEADBEEF, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'h010, 32'h0,        1, 32'hA5A5A5A5, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'h005, 32'h0,        5, 32'hDEADBEEF, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 32'h1FF, 32'hCAFEF00D, 1, 32'hDEADBEEF, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'h1FF, 32'h0,        1, 32'hCAFEF00D, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 32'h200, 32'h77777777, 1, 32'hCAFEF00D, e8};

        // Reset state, checked while reset is still asserted
        #12;
        for (int s = 0; s < 4; s++) begin
            if (s != 2) begin
                chk($sformatf("rst_ready%0d", s), {31'd0, g_rdy(s)}, 32'd0);
                chk($sformatf("rst_busy%0d", s), {31'd0, g_busy(s)}, 32'd0);
                chk($sformatf("rst_err%0d", s), {31'd0, g_err(s)}, 32'd0);
                chk($sformatf("rst_rdata%0d", s), g_rdata(s), 32'd0);
            end
        end
        @(negedge clk);
        rst = 4'h0;

        // WAIT_CYCLES=1 table: ready at accept+2, one pulse, busy seen
        for (int i = 0; i < 11; i++) begin
            txn(1, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].hold, lat, nrdy, rdat, busy);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
            chk($sformatf("v%0d_ready_pulses", i), 32'(nrdy), 32'd1);
            chk($sformatf("v%0d_rdata", i), rdat, vecs[i].exp_rdata);
            chk($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
            chk($sformatf("v%0d_addr_err", i), {31'd0, g_err(1)}, {31'd0, vecs[i].exp_err});
        end

        // WAIT_CYCLES=0: completion one cycle after accept, busy never high
        txn(0, 1'b0, 1'b1, 32'h1FF, 32'h12345678, 1, lat, nrdy, rdat, busy);
        chk("w0_wr_latency", 32'(lat), 32'd1);
        chk("w0_wr_busy", {31'd0, busy}, 32'd0);
        txn(0, 1'b1, 1'b0, 32'h1FF, 32'h0, 1, lat, nrdy, rdat, busy);
        chk("w0_rd_latency", 32'(lat), 32'd1);
        chk("w0_rd_pulses", 32'(nrdy), 32'd1);
        chk("w0_rd_rdata", rdat, 32'h12345678);
        chk("w0_rd_busy", {31'd0, busy}, 32'd0);
        txn(0, 1'b1, 1'b0, 32'h1FF, 32'h0, 6, lat, nrdy, rdat, busy);
        chk("w0_hold_pulses", 32'(nrdy), 32'd1);

        // WAIT_CYCLES=3: reset aborts a write before its commit edge
        txn(3, 1'b0, 1'b1, 32'h20, 32'h0BADF00D, 1, lat, nrdy, rdat, busy);
        chk("w3_wr_latency", 32'(lat), 32'd4);
        txn(3, 1'b1, 1'b0, 32'h20, 32'h0, 1, lat, nrdy, rdat, busy);
        chk("w3_rd_rdata", rdat, 32'h0BADF00D);
        @(negedge clk);
        t_rd = 1'b0; t_wr = 1'b1; t_addr = 32'h20; t_wdata = 32'h11111111; en[3] = 1'b1;
        @(negedge clk);
        chk("w3_busy_before_reset", {31'd0, g_busy(3)}, 32'd1);
        rst[3] = 1'b1; en[3] = 1'b0; t_wr = 1'b0;
        #1;
        chk("w3_reset_busy", {31'd0, g_busy(3)}, 32'd0);
        chk("w3_reset_ready", {31'd0, g_rdy(3)}, 32'd0);
        chk("w3_reset_rdata", g_rdata(3), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst[3] = 1'b0;
        txn(3, 1'b1, 1'b0, 32'h20, 32'h0, 1, lat, nrdy, rdat, busy);
        chk("w3_after_reset_latency", 32'(lat), 32'd4);
        chk("w3_after_reset_rdata", rdat, 32'h0BADF00D);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the control unit's memory strobes (read, write, 512x32 enable).
- Latches the MAR address and MDR write data on an accepted request and runs a parameterised wait-state access against an internal DEPTH x DATA_WIDTH array.
- Returns read data and a one-cycle ready pulse to the datapath.
- Sits between MAR/MDR and the MDR read-data mux; replaces a bare combinational RAM so memory latency can be modelled.

Parameters:
- DATA_WIDTH, 32, word width of address bus, write data and read data.
- ADDR_BITS, 9, address bits used; DEPTH = 2**ADDR_BITS (512 words).
- WAIT_CYCLES, 1, extra cycles between accept and completion; legal range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_enable  in  1  request qualifier (control unit 512x32 enable).
- mem_read  in  1  read request strobe.
- mem_write  in  1  write request strobe.
- addr  in  DATA_WIDTH  MAR contents; bits [ADDR_BITS-1:0] index the array.
- wdata  in  DATA_WIDTH  MDR contents for writes.
- rdata  out  DATA_WIDTH  read result; held until the next completed read.
- mem_ready  out  1  one-cycle pulse on completion of any access.
- mem_busy  out  1  high from accept until completion (WAIT state).
- addr_err  out  1  sticky out-of-range flag (only with the optional feature; otherwise tied 0).

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, rdata=0, mem_ready=0, mem_busy=0, addr_err=0, wait counter=0, latched op/addr/data=0. Array contents are not cleared.
- Accept condition: state==IDLE & mem_enable & (mem_read | mem_write).
  - If read and write are both asserted, write wins.
  - On accept, latch op, addr[ADDR_BITS-1:0] and wdata. Upper addr bits are ignored unless the optional feature is enabled.
- FSM states: IDLE, WAIT, DONE, HOLD.
  - IDLE: on accept, go to WAIT with counter=WAIT_CYCLES. If WAIT_CYCLES==0, go directly to DONE and perform the array operation on the accept edge.
  - WAIT: mem_busy=1. Decrement the counter each cycle. On the edge where the counter==1, perform the array operation (write commits, or read loads rdata) and go to DONE.
  - DONE: mem_ready=1 for exactly this cycle. Next state is HOLD if mem_enable is still high, else IDLE.
  - HOLD: wait for mem_enable==0, then go to IDLE. This prevents a strobe held across several states from causing a second access.
- Latency: mem_ready is high WAIT_CYCLES+1 cycles after the accept edge. rdata is valid in the same cycle as mem_ready.
- Strobe changes during WAIT/DONE/HOLD are ignored; the latched values are used.
- Write data is sampled at accept, not at commit.
- A write does not change rdata.
- Reset mid-access: the access is aborted and no array write occurs unless the commit edge has already passed.
- Read-after-write to the same address returns the new data, because the accesses are serialised by the FSM.

Optional Feature:
- Macro: MEM_RESPONDER_ADDR_CHECK_EN.
- Defined:
  - An accepted request with any addr[DATA_WIDTH-1:ADDR_BITS] bit set sets addr_err=1.
  - addr_err stays set until reset.
  - The access still completes with mem_ready, but writes are suppressed and reads return 0.
- Undefined: addr_err is tied 0 and upper address bits are silently truncated.

Decomposition:
- Shared package mem_pkg:
  - FSM state encoding (IDLE/WAIT/DONE/HOLD, 2 bits).
  - Default DATA_WIDTH/ADDR_BITS.
  - Opcode localparams OP_READ/OP_WRITE.
- One sub-module: mem_array_512x32, a synchronous single-port array with write-enable and registered read. mem_responder owns the FSM, latching, counter and flags.

Test Plan:
- WAIT_CYCLES=1: write 0xDEADBEEF to addr 0x05 (enable+write for 1 cycle) -> mem_ready pulses 2 cycles after accept. Then read 0x05 -> rdata=0xDEADBEEF together with mem_ready.
- WAIT_CYCLES=0: read addr 0x1FF after writing 0x12345678 -> mem_ready in cycle accept+1, rdata=0x12345678, mem_busy never high.
- Enable+read held high for 5 cycles -> exactly one mem_ready pulse; FSM stays in HOLD until enable drops, then IDLE.
- Read and write asserted together, addr 0x10, wdata 0xA5A5A5A5 -> write performed; a subsequent read returns 0xA5A5A5A5, and rdata is unchanged by the write itself.
- WAIT_CYCLES=3: assert reset one cycle after accepting a write of 0x11111111 to 0x20 -> all outputs 0 immediately, and a later read of 0x20 returns its prior value.
- With MEM_RESPONDER_ADDR_CHECK_EN: write to addr 0x00000200 -> addr_err=1, mem_ready pulses, and a read of 0x000 is unchanged.
